// File: rtl/axi_burst_master_if.sv
// AXI-style bus between axi_burst_master and a slave/interconnect.
// Carries the five channels: AR/R (read address/data), AW/W/B (write
// address/data/response). The master modport drives VALIDs, payloads and
// RREADY/BREADY; the slave modport is the mirror image.
interface axi_burst_master_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int ID_W   = 4,
    parameter int LEN_W  = 4
) ();
    logic              ARVALID;
    logic              ARREADY;
    logic [ADDR_W-1:0] ARADDR;
    logic [LEN_W-1:0]  ARLEN;
    logic [ID_W-1:0]   ARID;

    logic              RVALID;
    logic              RREADY;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RLAST;
    logic [ID_W-1:0]   RID;

    logic              AWVALID;
    logic              AWREADY;
    logic [ADDR_W-1:0] AWADDR;
    logic [LEN_W-1:0]  AWLEN;
    logic [ID_W-1:0]   AWID;

    logic              WVALID;
    logic              WREADY;
    logic [DATA_W-1:0] WDATA;
    logic              WLAST;

    logic              BVALID;
    logic              BREADY;
    logic [1:0]        BRESP;
    logic [ID_W-1:0]   BID;

    modport master (
        output ARVALID, ARADDR, ARLEN, ARID, input ARREADY,
        input  RVALID, RDATA, RRESP, RLAST, RID, output RREADY,
        output AWVALID, AWADDR, AWLEN, AWID, input AWREADY,
        output WVALID, WDATA, WLAST, input WREADY,
        input  BVALID, BRESP, BID, output BREADY
    );

    modport slave (
        input  ARVALID, ARADDR, ARLEN, ARID, output ARREADY,
        output RVALID, RDATA, RRESP, RLAST, RID, input RREADY,
        input  AWVALID, AWADDR, AWLEN, AWID, output AWREADY,
        input  WVALID, WDATA, WLAST, output WREADY,
        output BVALID, BRESP, BID, input BREADY
    );
endinterface

// File: rtl/axi_burst_master.sv
// AXI-style burst master with independent read and write engines.
// Each engine accepts a one-cycle command (when not busy), performs one
// address handshake, moves len+1 beats and pulses *_done with *_err.
// Ports:
//   clk, rst               clock, async active-high reset
//   rd_start/addr/len/id   read command; rd_busy/rd_done/rd_err status
//   rd_buf                 received beats, beat k at [k*DATA_W +: DATA_W]
//   wr_start/addr/len/id   write command; wr_data holds all beats
//   wr_busy/done/err       write status; wr_bresp = captured BRESP
//   bus                    AXI channels (master modport)
module axi_burst_master #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int ID_W   = 4,
    parameter int LEN_W  = 4,
    localparam int MAX_BEATS = 2 ** LEN_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rd_start,
    input  logic [ADDR_W-1:0]             rd_addr,
    input  logic [LEN_W-1:0]              rd_len,
    input  logic [ID_W-1:0]               rd_id,
    output logic                          rd_busy,
    output logic                          rd_done,
    output logic                          rd_err,
    output logic [MAX_BEATS*DATA_W-1:0]   rd_buf,
    input  logic                          wr_start,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [LEN_W-1:0]              wr_len,
    input  logic [ID_W-1:0]               wr_id,
    input  logic [MAX_BEATS*DATA_W-1:0]   wr_data,
    output logic                          wr_busy,
    output logic                          wr_done,
    output logic                          wr_err,
    output logic [1:0]                    wr_bresp,
    axi_burst_master_if.master            bus
);

    // ---------------- read engine ----------------
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
    rd_state_t rd_state, rd_next;

    logic [ADDR_W-1:0] rd_addr_q;
    logic [LEN_W-1:0]  rd_len_q;
    logic [ID_W-1:0]   rd_id_q;
    logic [LEN_W:0]    rd_cnt;     // one spare bit so len=MAX-1 never wraps
    logic              rd_last_beat;
    logic              rd_beat_err;

    assign rd_last_beat = (rd_cnt == {1'b0, rd_len_q});
    // RLAST must appear exactly on beat len; either misplacement is an error
    assign rd_beat_err  = (bus.RRESP != 2'b00) || (bus.RID != rd_id_q) ||
                          (bus.RLAST != rd_last_beat);

    assign bus.ARADDR = rd_addr_q;
    assign bus.ARLEN  = rd_len_q;
    assign bus.ARID   = rd_id_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_state <= R_IDLE;
        else     rd_state <= rd_next;
    end

    always_comb begin
        rd_next     = rd_state;
        rd_busy     = 1'b1;
        bus.ARVALID = 1'b0;
        bus.RREADY  = 1'b0;
        case (rd_state)
            R_IDLE: begin
                rd_busy = 1'b0;
                if (rd_start) rd_next = R_ADDR;
            end
            R_ADDR: begin
                bus.ARVALID = 1'b1;
                if (bus.ARREADY) rd_next = R_DATA;
            end
            R_DATA: begin
                bus.RREADY = 1'b1;
                // burst length is governed by len, not by RLAST
                if (bus.RVALID && rd_last_beat) rd_next = R_IDLE;
            end
            default: rd_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr_q <= '0;
            rd_len_q  <= '0;
            rd_id_q   <= '0;
            rd_cnt    <= '0;
            rd_err    <= 1'b0;
            rd_done   <= 1'b0;
            rd_buf    <= '0;
        end else begin
            rd_done <= 1'b0;
            case (rd_state)
                R_IDLE: if (rd_start) begin
                    rd_addr_q <= rd_addr;
                    rd_len_q  <= rd_len;
                    rd_id_q   <= rd_id;
                    rd_cnt    <= '0;
                    rd_err    <= 1'b0;
                end
                R_DATA: if (bus.RVALID) begin
                    rd_buf[int'(rd_cnt[LEN_W-1:0]) * DATA_W +: DATA_W] <= bus.RDATA;
                    rd_cnt <= rd_cnt + 1'b1;
                    if (rd_beat_err) rd_err <= 1'b1;
                    if (rd_last_beat) rd_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ---------------- write engine ----------------
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;
    wr_state_t wr_state, wr_next;

    logic [ADDR_W-1:0]           wr_addr_q;
    logic [LEN_W-1:0]            wr_len_q;
    logic [ID_W-1:0]             wr_id_q;
    logic [LEN_W:0]              wr_cnt;
    logic [MAX_BEATS*DATA_W-1:0] wr_buf;   // shifts down one beat per handshake
    logic                        wr_last_beat;

    assign wr_last_beat = (wr_cnt == {1'b0, wr_len_q});

    // current beat always sits in the low slot: WDATA is a plain register
    assign bus.WDATA  = wr_buf[DATA_W-1:0];
    assign bus.AWADDR = wr_addr_q;
    assign bus.AWLEN  = wr_len_q;
    assign bus.AWID   = wr_id_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wr_state <= W_IDLE;
        else     wr_state <= wr_next;
    end

    always_comb begin
        wr_next     = wr_state;
        wr_busy     = 1'b1;
        bus.AWVALID = 1'b0;
        bus.WVALID  = 1'b0;
        bus.WLAST   = 1'b0;
        bus.BREADY  = 1'b0;
        case (wr_state)
            W_IDLE: begin
                wr_busy = 1'b0;
                if (wr_start) wr_next = W_ADDR;
            end
            W_ADDR: begin
                bus.AWVALID = 1'b1;
                if (bus.AWREADY) wr_next = W_DATA;
            end
            W_DATA: begin
                bus.WVALID = 1'b1;
                bus.WLAST  = wr_last_beat;
                if (bus.WREADY && wr_last_beat) wr_next = W_RESP;
            end
            W_RESP: begin
                bus.BREADY = 1'b1;
                if (bus.BVALID) wr_next = W_IDLE;
            end
            default: wr_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr_q <= '0;
            wr_len_q  <= '0;
            wr_id_q   <= '0;
            wr_cnt    <= '0;
            wr_buf    <= '0;
            wr_err    <= 1'b0;
            wr_done   <= 1'b0;
            wr_bresp  <= 2'b00;
        end else begin
            wr_done <= 1'b0;
            case (wr_state)
                W_IDLE: if (wr_start) begin
                    wr_addr_q <= wr_addr;
                    wr_len_q  <= wr_len;
                    wr_id_q   <= wr_id;
                    wr_buf    <= wr_data;
                    wr_cnt    <= '0;
                    wr_err    <= 1'b0;
                end
                W_DATA: if (bus.WREADY) begin
                    wr_buf <= wr_buf >> DATA_W;
                    wr_cnt <= wr_cnt + 1'b1;
                end
                W_RESP: if (bus.BVALID) begin
                    wr_bresp <= bus.BRESP;
                    wr_err   <= (bus.BRESP != 2'b00) || (bus.BID != wr_id_q);
                    wr_done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_burst_master.sv
module tb_axi_burst_master;
    localparam int ADDR_W = 8, DATA_W = 8, ID_W = 4, LEN_W = 4;
    localparam int MAXB = 16, BW = MAXB * DATA_W;

    logic clk = 1'b0, rst = 1'b1;
    logic rd_start = 0, wr_start = 0;
    logic [ADDR_W-1:0] rd_addr = 0, wr_addr = 0;
    logic [LEN_W-1:0]  rd_len = 0, wr_len = 0;
    logic [ID_W-1:0]   rd_id = 0, wr_id = 0;
    logic [BW-1:0]     wr_data = 0, rd_buf;
    logic rd_busy, rd_done, rd_err, wr_busy, wr_done, wr_err;
    logic [1:0] wr_bresp;

    axi_burst_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .LEN_W(LEN_W)) bus ();

    axi_burst_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst),
        .rd_start(rd_start), .rd_addr(rd_addr), .rd_len(rd_len), .rd_id(rd_id),
        .rd_busy(rd_busy), .rd_done(rd_done), .rd_err(rd_err), .rd_buf(rd_buf),
        .wr_start(wr_start), .wr_addr(wr_addr), .wr_len(wr_len), .wr_id(wr_id),
        .wr_data(wr_data), .wr_busy(wr_busy), .wr_done(wr_done), .wr_err(wr_err),
        .wr_bresp(wr_bresp), .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // scoreboard entries
    typedef struct { logic [BW-1:0] buf_v; logic err; } rexp_t;
    typedef struct { logic [DATA_W-1:0] d; logic last; } wexp_t;
    typedef struct { logic [1:0] resp; logic err; } bexp_t;
    rexp_t rq[$];
    wexp_t wq[$];
    bexp_t bq[$];
    int rd_exp_n = 0, wr_exp_n = 0, rd_done_n = 0, wr_done_n = 0;
    logic [BW-1:0] mbuf = '0;   // model of rd_buf

    // slave configuration
    int ar_delay = 0, aw_delay = 0, r_last_at = 0, r_n = 0;
    logic [DATA_W-1:0] r_dat [MAXB];
    logic [ID_W-1:0] r_id_v = 0, b_id_v = 0;
    logic [1:0] r_resp_v = 0, b_resp_v = 0;
    bit w_toggle = 0;
    logic [ADDR_W-1:0] exp_ar_addr = 0, exp_aw_addr = 0;
    logic [LEN_W-1:0]  exp_ar_len = 0, exp_aw_len = 0;
    logic [ID_W-1:0]   exp_ar_id = 0, exp_aw_id = 0;
    int r_idx = 0;

    // slave model + monitors: sample at negedge, drive at posedge+1
    initial begin
        int ar_cnt, aw_cnt;
        bit ar_hs, r_hs, aw_hs, w_hs, b_hs, aw_seen, b_pend, w_stalled, rd_prev, wr_prev;
        logic [DATA_W-1:0] w_prev;
        rexp_t re; wexp_t we; bexp_t be;
        ar_cnt = 0; aw_cnt = 0; aw_seen = 0; b_pend = 0; w_stalled = 0;
        rd_prev = 0; wr_prev = 0; w_prev = 0;
        bus.ARREADY = 0; bus.RVALID = 0; bus.RDATA = 0; bus.RRESP = 0; bus.RLAST = 0; bus.RID = 0;
        bus.AWREADY = 0; bus.WREADY = 0; bus.BVALID = 0; bus.BRESP = 0; bus.BID = 0;
        forever begin
            @(negedge clk);
            ar_hs = bus.ARVALID && bus.ARREADY;
            r_hs  = bus.RVALID && bus.RREADY;
            aw_hs = bus.AWVALID && bus.AWREADY;
            w_hs  = bus.WVALID && bus.WREADY;
            b_hs  = bus.BVALID && bus.BREADY;
            if (ar_hs) begin
                chk("araddr", bus.ARADDR, exp_ar_addr);
                chk("arlen", bus.ARLEN, exp_ar_len);
                chk("arid", bus.ARID, exp_ar_id);
            end
            if (aw_hs) begin
                chk("awaddr", bus.AWADDR, exp_aw_addr);
                chk("awlen", bus.AWLEN, exp_aw_len);
                chk("awid", bus.AWID, exp_aw_id);
                aw_seen = 1;
            end
            if (bus.WVALID) chk("w_after_aw", aw_seen, 1);
            if (w_stalled) chk("wdata_hold", bus.WDATA, w_prev);
            w_stalled = bus.WVALID && !bus.WREADY;
            w_prev = bus.WDATA;
            if (w_hs) begin
                if (wq.size() == 0) chk("w_unexp", 1, 0);
                else begin
                    we = wq.pop_front();
                    chk("wdata", bus.WDATA, we.d);
                    chk("wlast", bus.WLAST, we.last);
                end
                if (bus.WLAST) begin aw_seen = 0; b_pend = 1; end
            end
            if (rd_done) begin
                rd_done_n++;
                chk("rd_done_1cyc", rd_prev, 0);
                if (rq.size() == 0) chk("rd_done_unexp", 1, 0);
                else begin
                    re = rq.pop_front();
                    chk("rd_buf", rd_buf, re.buf_v);
                    chk("rd_err", rd_err, re.err);
                end
            end
            rd_prev = rd_done;
            if (wr_done) begin
                wr_done_n++;
                chk("wr_done_1cyc", wr_prev, 0);
                if (bq.size() == 0) chk("wr_done_unexp", 1, 0);
                else begin
                    be = bq.pop_front();
                    chk("wr_bresp", wr_bresp, be.resp);
                    chk("wr_err", wr_err, be.err);
                end
            end
            wr_prev = wr_done;

            @(posedge clk); #1;
            if (rst) begin
                bus.ARREADY = 0; bus.RVALID = 0; bus.RLAST = 0; bus.AWREADY = 0;
                bus.WREADY = 0; bus.BVALID = 0;
                ar_cnt = 0; aw_cnt = 0; aw_seen = 0; b_pend = 0; w_stalled = 0;
                rd_prev = 0; wr_prev = 0; r_idx = 0;
                continue;
            end
            bus.ARREADY = 0;
            if (bus.ARVALID) begin
                if (ar_cnt >= ar_delay) bus.ARREADY = 1; else ar_cnt++;
            end else ar_cnt = 0;
            if (ar_hs || r_hs) begin
                r_idx = ar_hs ? 0 : r_idx + 1;
                if (r_idx < r_n) begin
                    bus.RVALID = 1; bus.RDATA = r_dat[r_idx];
                    bus.RLAST = (r_idx == r_last_at); bus.RID = r_id_v; bus.RRESP = r_resp_v;
                end else begin
                    bus.RVALID = 0; bus.RLAST = 0;
                end
            end
            bus.AWREADY = 0;
            if (bus.AWVALID) begin
                if (aw_cnt >= aw_delay) bus.AWREADY = 1; else aw_cnt++;
            end else aw_cnt = 0;
            bus.WREADY = w_toggle ? !bus.WREADY : 1'b1;
            if (b_hs) bus.BVALID = 0;
            if (b_pend) begin
                bus.BVALID = 1; bus.BRESP = b_resp_v; bus.BID = b_id_v; b_pend = 0;
            end
        end
    end

    task automatic rd_go(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l, input logic [ID_W-1:0] id,
                         input int dly, input logic [ID_W-1:0] rid, input int last_at, input logic e);
        ar_delay = dly; r_n = int'(l) + 1; r_last_at = last_at; r_id_v = rid; r_resp_v = 0;
        exp_ar_addr = a; exp_ar_len = l; exp_ar_id = id;
        for (int k = 0; k <= int'(l); k++) mbuf[k*DATA_W +: DATA_W] = r_dat[k];
        rq.push_back('{mbuf, e});
        rd_exp_n++;
        @(posedge clk); #1;
        rd_start = 1; rd_addr = a; rd_len = l; rd_id = id;
        @(posedge clk); #1;
        rd_start = 0; rd_addr = 8'($urandom); rd_len = 4'($urandom); rd_id = 4'($urandom);
    endtask

    task automatic wr_go(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l, input logic [ID_W-1:0] id,
                         input logic [BW-1:0] d, input int dly, input bit tog,
                         input logic [1:0] bresp, input logic [ID_W-1:0] bid, input logic e);
        aw_delay = dly; w_toggle = tog; b_resp_v = bresp; b_id_v = bid;
        exp_aw_addr = a; exp_aw_len = l; exp_aw_id = id;
        for (int k = 0; k <= int'(l); k++) wq.push_back('{d[k*DATA_W +: DATA_W], k == int'(l)});
        bq.push_back('{bresp, e});
        wr_exp_n++;
        @(posedge clk); #1;
        wr_start = 1; wr_addr = a; wr_len = l; wr_id = id; wr_data = d;
        @(posedge clk); #1;
        wr_start = 0; wr_data = {4{$urandom}};   // must already be latched
    endtask

    task automatic wait_rd();
        int n = 0;
        while (rd_done_n < rd_exp_n && n < 200) begin @(posedge clk); n++; end
        if (rd_done_n < rd_exp_n) chk("rd_timeout", rd_done_n, rd_exp_n);
    endtask

    task automatic wait_wr();
        int n = 0;
        while (wr_done_n < wr_exp_n && n < 200) begin @(posedge clk); n++; end
        if (wr_done_n < wr_exp_n) chk("wr_timeout", wr_done_n, wr_exp_n);
    endtask

    task automatic rand_rdat();
        for (int k = 0; k < MAXB; k++) r_dat[k] = 8'($urandom);
    endtask

    initial begin
        logic [BW-1:0] d;
        int n, n0;
        for (int k = 0; k < MAXB; k++) r_dat[k] = 0;
        #12;
        chk("rst_ctrl", {bus.ARVALID, bus.RREADY, bus.AWVALID, bus.WVALID, bus.WLAST, bus.BREADY,
                         rd_busy, rd_done, rd_err, wr_busy, wr_done, wr_err}, 0);
        chk("rst_rdbuf", rd_buf, 0);
        chk("rst_bresp", wr_bresp, 0);
        chk("rst_wdata", bus.WDATA, 0);
        @(posedge clk); #2; rst = 0;

        // read len=3, ARREADY one cycle late
        r_dat[0] = 8'h11; r_dat[1] = 8'h22; r_dat[2] = 8'h33; r_dat[3] = 8'h44;
        rd_go(8'h40, 4'd3, 4'd5, 1, 4'd5, 3, 1'b0);
        wait_rd();
        chk("rd_word0", rd_buf[31:0], 32'h44332211);

        // single-beat write with AWREADY delayed
        d = {4{$urandom}}; d[7:0] = 8'hA5;
        wr_go(8'h10, 4'd0, 4'd3, d, 3, 0, 2'b00, 4'd3, 1'b0);
        wait_wr();
        chk("wq_empty", wq.size(), 0);

        // full-length write with WREADY toggling
        d = {$urandom, $urandom, $urandom, $urandom};
        wr_go(8'h80, 4'd15, 4'd9, d, 0, 1, 2'b00, 4'd9, 1'b0);
        wait_wr();
        w_toggle = 0;

        // RLAST early, then RID mismatch: both still run len+1 beats
        rand_rdat();
        rd_go(8'h44, 4'd3, 4'd5, 0, 4'd5, 1, 1'b1);
        wait_rd();
        rand_rdat();
        rd_go(8'h48, 4'd3, 4'd5, 0, 4'd6, 3, 1'b1);
        wait_rd();
        // single-beat read, higher slots untouched
        rand_rdat();
        rd_go(8'h4C, 4'd0, 4'd2, 2, 4'd2, 0, 1'b0);
        wait_rd();

        // error BRESP + concurrent full read + ignored second write
        rand_rdat();
        rd_go(8'hC0, 4'd15, 4'd1, 0, 4'd1, 15, 1'b0);
        d = {$urandom, $urandom, $urandom, $urandom};
        wr_go(8'h20, 4'd2, 4'd7, d, 4, 0, 2'b10, 4'd7, 1'b1);
        chk("wr_busy", wr_busy, 1);
        wr_start = 1; wr_addr = 8'hEE; wr_len = 4'd5; wr_id = 4'd1; wr_data = ~d;
        @(posedge clk); #1; wr_start = 0;
        wait_rd();
        wait_wr();
        chk("wq_empty2", wq.size(), 0);

        // reset in the middle of a read (beat 2 on the bus)
        rand_rdat();
        rd_go(8'h60, 4'd7, 4'd4, 0, 4'd4, 7, 1'b0);
        n = 0;
        while (!(bus.RVALID && r_idx == 2) && n < 50) begin @(posedge clk); #2; n++; end
        chk("reach_beat2", r_idx, 2);
        rst = 1; #1;
        chk("rst_mid", {bus.ARVALID, bus.RREADY, rd_busy, rd_done}, 0);
        chk("rst_mid_buf", rd_buf, 0);
        void'(rq.pop_back()); rd_exp_n--; mbuf = '0;
        n0 = rd_done_n;
        repeat (3) @(posedge clk);
        #2; rst = 0;
        repeat (3) @(posedge clk);
        chk("no_done_rst", rd_done_n, n0);

        // normal read after reset
        rand_rdat();
        rd_go(8'h70, 4'd5, 4'd3, 1, 4'd3, 5, 1'b0);
        wait_rd();
        repeat (3) @(posedge clk);
        chk("rq_empty", rq.size(), 0);
        chk("bq_empty", bq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_burst_master.md
Name: axi_burst_master

Overview:
Parametrised AXI-style bus master with independent read and write engines. Each engine takes a one-cycle command from local control logic, issues a single address-phase handshake, moves a burst of 1..2^LEN_W beats, and reports completion with captured status. It sits between the testbench/controller logic and the slave/interconnect. It adds to the previous single-channel master: configurable widths, ID checking, response error capture, burst-length protocol checking and a read data buffer.

Parameters:
ADDR_W, 8, address width
DATA_W, 8, beat data width
ID_W, 4, transaction ID width
LEN_W, 4, burst length field width; beats = len+1, MAX_BEATS = 2^LEN_W

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
rd_start  in  1  read command strobe; accepted only when rd_busy=0
rd_addr/rd_len/rd_id  in  ADDR_W/LEN_W/ID_W  read command fields
rd_busy  out  1  read engine not IDLE
rd_done  out  1  one-cycle pulse when the read burst completes
rd_err  out  1  valid with rd_done: RRESP!=0, RID mismatch or RLAST misplacement
rd_buf  out  MAX_BEATS*DATA_W  received beats; beat k in [k*DATA_W +: DATA_W]
wr_start  in  1  write command strobe; accepted only when wr_busy=0
wr_addr/wr_len/wr_id  in  ADDR_W/LEN_W/ID_W  write command fields
wr_data  in  MAX_BEATS*DATA_W  write beats, sampled at wr_start
wr_busy, wr_done, wr_err  out  1 each  as read; wr_err = BRESP!=0 or BID mismatch
wr_bresp  out  2  BRESP captured at B handshake
ARVALID out 1; ARREADY in 1; ARADDR out ADDR_W; ARLEN out LEN_W; ARID out ID_W
RVALID in 1; RREADY out 1; RDATA in DATA_W; RRESP in 2; RLAST in 1; RID in ID_W
AWVALID out 1; AWREADY in 1; AWADDR out ADDR_W; AWLEN out LEN_W; AWID out ID_W
WVALID out 1; WREADY in 1; WDATA out DATA_W; WLAST out 1
BVALID in 1; BREADY out 1; BRESP in 2; BID in ID_W

Behaviour:
- Reset (async): both FSMs go to IDLE. All outputs are 0, including rd_buf, wr_bresp and the latched command and data registers. Reset mid-burst abandons the burst immediately with no done pulse.
- Handshake: a transfer occurs on a clk edge with VALID&READY high. Once raised, a VALID and its payload stay stable until the handshake. A master never waits for READY before raising VALID.
- Read FSM R_IDLE -> R_ADDR -> R_DATA -> R_IDLE:
  - R_IDLE: when rd_start=1, latch addr/len/id, clear the beat counter and error flag, raise ARVALID next cycle. The rd_busy rise and the ARVALID rise are registered on the same edge.
  - R_ADDR: ARVALID=1, AR fields = latched values. On ARREADY, drop ARVALID and raise RREADY next cycle.
  - R_DATA: RREADY=1. Each RVALID beat is written to rd_buf slot cnt, then cnt increments (LEN_W+1 bits).
  - Error flags: set rd_err if RRESP!=0 or RID!=latched id on any beat. Also set it if RLAST=1 on a beat other than beat len, or RLAST=0 on beat len.
  - Termination: the burst ends on the beat where cnt==len, regardless of RLAST. Next cycle: RREADY=0, rd_done=1 for one cycle, rd_err valid, return to R_IDLE. Extra beats after termination are not accepted (RREADY=0).
- Write FSM W_IDLE -> W_ADDR -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: when wr_start=1, latch addr/len/id and all of wr_data.
  - W_ADDR: AWVALID=1 until AWREADY. WVALID is not raised before the AW handshake.
  - W_DATA: WVALID=1, WDATA = beat cnt, WLAST = (cnt==len). On each WREADY handshake cnt increments and WDATA advances combinationally-free: the next beat is registered on the same edge, so back-to-back beats occur with WREADY held high. After the last beat, WVALID=0 and WLAST=0 next cycle.
  - W_RESP: BREADY=1. On BVALID, capture BRESP into wr_bresp, set wr_err if BRESP!=0 or BID!=latched id. Drop BREADY, pulse wr_done, return to W_IDLE.
- Single-beat bursts (len=0): one beat with WLAST=1 (write) or one beat expected with RLAST=1 (read).
- Full burst (len=2^LEN_W-1): cnt must reach len without overflow.
- The read and write engines are fully independent and may run concurrently. rd_start or wr_start while busy is ignored.
- rd_buf slots above len keep values from previous bursts; they are only cleared by reset.

Test Plan:
- Read len=3, addr=0x40, id=5; slave returns 0x11,0x22,0x33,0x44 with RLAST on beat 3 and 1-cycle ARREADY delay -> rd_buf[31:0]=0x44332211, rd_done one cycle, rd_err=0.
- Write len=0, wr_data[7:0]=0xA5, AWREADY delayed 3 cycles -> exactly one W beat 0xA5 with WLAST=1, WVALID only after the AW handshake, wr_done, wr_bresp=0.
- Write len=15 with WREADY toggling every other cycle -> 16 beats in order, WDATA stable while stalled, WLAST only on beat 15.
- Read with RLAST on beat 1 of len=3, or RID=6 vs id 5 -> burst still completes after 4 beats, rd_err=1.
- Write BRESP=2'b10 -> wr_bresp=2, wr_err=1. Concurrently run a read plus a wr_start while wr_busy=1 -> the second write is ignored and the read completes unaffected.
- Assert rst mid read beat 2 -> ARVALID/RREADY/rd_busy=0 immediately, no rd_done. A new rd_start after reset runs normally.
